// File: rtl/ps2_rx_ctrl_if.sv
// Signal bundle between the PS/2 receive controller and its surroundings.
// Latency: none, wires only.
// Backpressure: none; the event pulses are fire-and-forget.
interface ps2_rx_ctrl_if;
  logic       rx_en;
  logic       ps2_clk_filt;
  logic       ps2_data_filt;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_break;
  logic       busy;

  // Controller side: consumes the filtered lines, produces byte/key events.
  modport master (
    input  rx_en, ps2_clk_filt, ps2_data_filt,
    output byte_valid, byte_data, frame_err, key_valid, key_code, key_break, busy
  );

  // Keyboard-logic side: drives enable and lines, consumes events.
  modport slave (
    output rx_en, ps2_clk_filt, ps2_data_filt,
    input  byte_valid, byte_data, frame_err, key_valid, key_code, key_break, busy
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: frames 11-bit packets, checks start/parity/stop, decodes E0/F0 key events.
// Latency: byte/key/error pulses one clk after the stop-bit falling edge (or after the timeout limit).
// Backpressure: none; every output event is a single-cycle pulse the consumer must take as it comes.
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input logic           clk,
  input logic           resetN,
  ps2_rx_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 clk_d;
  logic                 fall;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt;
  logic                 parity_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_hit;
  logic                 ext_q;
  logic                 brk_q;

  logic                 start_frame;
  logic                 shift_en;
  logic                 parity_en;
  logic                 frame_good;
  logic                 frame_bad;
  logic                 abort;

  logic                 byte_valid_q;
  logic [7:0]           byte_data_q;
  logic                 frame_err_q;
  logic                 key_valid_q;
  logic [8:0]           key_code_q;
  logic                 key_break_q;
  logic                 busy_q;

  // clk_d resets low so the filters rising out of reset can never look like a falling edge.
  assign fall    = clk_d & ~bus.ps2_clk_filt;
  // A falling edge arriving in the limit cycle rescues the frame.
  assign tmo_hit = (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) & ~fall;

  // Previous-cycle copy of the filtered PS/2 clock for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) clk_d <= 1'b0;
    else         clk_d <= bus.ps2_clk_filt;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and datapath strobes; rx_en low beats a falling edge, which beats the timeout.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    parity_en   = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    abort       = 1'b0;
    if (!bus.rx_en) begin
      state_nxt = IDLE;
      abort     = (state != IDLE);
    end else begin
      unique case (state)
        IDLE: begin
          if (fall && !bus.ps2_data_filt) begin
            state_nxt   = DATA;
            start_frame = 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) state_nxt = PARITY;
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
          end
        end
        PARITY: begin
          if (fall) begin
            parity_en = 1'b1;
            state_nxt = STOP;
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
          end
        end
        STOP: begin
          if (fall) begin
            state_nxt = IDLE;
            if ((^shift_q ^ parity_q) && bus.ps2_data_filt) frame_good = 1'b1;
            else                                            frame_bad  = 1'b1;
          end else if (tmo_hit) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Mid-frame inactivity counter: held at zero while idle or leaving a frame, restarted by every edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                          tmo_cnt <= '0;
    else if (state == IDLE || state_nxt == IDLE || fall) tmo_cnt <= '0;
    else                                                  tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
  end

  // Data shift register (LSB arrives first, enters at bit 7), bit counter and parity capture.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shift_q  <= 8'h00;
      bit_cnt  <= 3'd0;
      parity_q <= 1'b0;
    end else begin
      if (start_frame) bit_cnt <= 3'd0;
      if (shift_en) begin
        shift_q <= {bus.ps2_data_filt, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (parity_en) parity_q <= bus.ps2_data_filt;
    end
  end

  // Output pulses, held byte/key values and the E0/F0 prefix flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      frame_err_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 9'h000;
      key_break_q  <= 1'b0;
      busy_q       <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      byte_valid_q <= frame_good;
      frame_err_q  <= frame_bad;
      key_valid_q  <= 1'b0;
      busy_q       <= (state_nxt != IDLE);
      if (frame_good) begin
        byte_data_q <= shift_q;
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          key_valid_q <= 1'b1;
          key_code_q  <= {ext_q, shift_q};
          key_break_q <= brk_q;
          ext_q       <= 1'b0;
          brk_q       <= 1'b0;
        end
      end else if (frame_bad || abort) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.key_break  = key_break_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: directed frame table, timeout/rx_en corner sequences, random frames vs a model.
// Latency: checks pulses land exactly one clk after the stop fall, timeout one clk after the limit.
// Backpressure: none; a negedge monitor counts every pulse the DUT emits.
module tb_ps2_rx_ctrl;
  localparam int TMO  = 100;
  localparam int HALF = 10;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  ps2_rx_ctrl_if bus();

  ps2_rx_ctrl #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          bv_cnt = 0, fe_cnt = 0, kv_cnt = 0, consec = 0;
  int unsigned bv_cyc = 0, fe_cyc = 0, last_fall = 0;
  logic        bv_p = 1'b0, fe_p = 1'b0, kv_p = 1'b0;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) begin bv_cnt++; bv_cyc = cyc; if (bv_p) consec++; end
    if (bus.frame_err  === 1'b1) begin fe_cnt++; fe_cyc = cyc; if (fe_p) consec++; end
    if (bus.key_valid  === 1'b1) begin kv_cnt++;               if (kv_p) consec++; end
    bv_p = (bus.byte_valid === 1'b1);
    fe_p = (bus.frame_err  === 1'b1);
    kv_p = (bus.key_valid  === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit i of f is the i-th bit on the wire (bit 0 = start).
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 bus.ps2_data_filt = f[i];
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk_filt = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(posedge clk);
      #1 bus.ps2_clk_filt = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic run_frame(input string name, input logic [10:0] f,
                           input bit e_bv, input bit e_fe, input bit e_kv,
                           input logic [8:0] e_code, input bit e_brk, input logic [7:0] e_bdata);
    int bv0, fe0, kv0;
    bv0 = bv_cnt; fe0 = fe_cnt; kv0 = kv_cnt;
    send_bits(f, 11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, ".byte_valid_cnt"}, bv_cnt - bv0, e_bv);
    chk({name, ".frame_err_cnt"},  fe_cnt - fe0, e_fe);
    chk({name, ".key_valid_cnt"},  kv_cnt - kv0, e_kv);
    chk({name, ".byte_data"},      bus.byte_data, e_bdata);
    chk({name, ".key_code"},       bus.key_code, e_code);
    chk({name, ".key_break"},      bus.key_break, e_brk);
    chk({name, ".busy"},           bus.busy, 1'b0);
    if (e_bv) chk({name, ".bv_timing"}, bv_cyc, last_fall + 1);
    if (e_fe) chk({name, ".fe_timing"}, fe_cyc, last_fall + 1);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    bit         e_bv;
    bit         e_fe;
    bit         e_kv;
    logic [8:0] e_code;
    bit         e_brk;
    logic [7:0] e_bdata;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int bv0, fe0, kv0;
    int unsigned rd;
    bit          m_ext, m_brk, m_kbrk;
    logic [8:0]  m_code;
    logic [7:0]  m_bdata, b;
    logic [10:0] f;

    // byte, bad_par, bad_stop, bv, fe, kv, key_code after, key_break after, byte_data after
    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h01C, 1'b0, 8'h1C};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h01C, 1'b0, 8'hF0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h01C, 1'b1, 8'h1C};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h01C, 1'b1, 8'hE0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h01C, 1'b1, 8'hF0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h175, 1'b1, 8'h75};
    tbl[6]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h01C, 1'b0, 8'h1C};
    tbl[7]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h01C, 1'b0, 8'h1C};
    tbl[8]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h01C, 1'b0, 8'hE0};
    tbl[9]  = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h01C, 1'b0, 8'hE0};
    tbl[10] = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h074, 1'b0, 8'h74};
    tbl[11] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h074, 1'b0, 8'hF0};
    tbl[12] = '{8'h6B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h074, 1'b0, 8'hF0};
    tbl[13] = '{8'h6B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h06B, 1'b0, 8'h6B};

    // Reset with both filtered lines low.
    bus.rx_en = 1'b0; bus.ps2_clk_filt = 1'b0; bus.ps2_data_filt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy",       bus.busy, 1'b0);
    chk("rst.byte_valid", bus.byte_valid, 1'b0);
    chk("rst.byte_data",  bus.byte_data, 8'h00);
    chk("rst.frame_err",  bus.frame_err, 1'b0);
    chk("rst.key_valid",  bus.key_valid, 1'b0);
    chk("rst.key_code",   bus.key_code, 9'h000);
    chk("rst.key_break",  bus.key_break, 1'b0);
    resetN = 1'b1; bus.rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst.busy", bus.busy, 1'b0);
    @(posedge clk); #1 bus.ps2_clk_filt = 1'b1; bus.ps2_data_filt = 1'b1;
    repeat (10) @(negedge clk);
    chk("lines_rise.busy",     bus.busy, 1'b0);
    chk("lines_rise.pulses",   bv_cnt + fe_cnt + kv_cnt, 0);

    // Falling edge with data high while idle is not a start bit.
    send_bits(11'h7FF, 1);
    repeat (3) @(negedge clk);
    chk("idle_fall_hi.busy",   bus.busy, 1'b0);
    chk("idle_fall_hi.pulses", bv_cnt + fe_cnt + kv_cnt, 0);

    // Directed frame table.
    for (int i = 0; i < 14; i++)
      run_frame($sformatf("tbl%0d", i), mk_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop),
                tbl[i].e_bv, tbl[i].e_fe, tbl[i].e_kv, tbl[i].e_code, tbl[i].e_brk, tbl[i].e_bdata);

    // Timeout after 4 data bits, with ext pending beforehand.
    run_frame("tmo.e0", mk_frame(8'hE0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 9'h06B, 1'b0, 8'hE0);
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_bits(mk_frame(8'h0F, 1'b0, 1'b0), 5);
    repeat (TMO + 20) @(negedge clk);
    chk("tmo.fe_cnt",    fe_cnt - fe0, 1);
    chk("tmo.fe_timing", fe_cyc, last_fall + TMO + 1);
    chk("tmo.bv_cnt",    bv_cnt - bv0, 0);
    chk("tmo.busy",      bus.busy, 1'b0);
    run_frame("tmo.after29", mk_frame(8'h29, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 9'h029, 1'b0, 8'h29);

    // rx_en dropped mid-frame, ext pending beforehand.
    run_frame("en.e0", mk_frame(8'hE0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 9'h029, 1'b0, 8'hE0);
    bv0 = bv_cnt; fe0 = fe_cnt; kv0 = kv_cnt;
    send_bits(mk_frame(8'h0F, 1'b0, 1'b0), 5);
    @(posedge clk); #1 bus.rx_en = 1'b0;
    rd = cyc;
    @(posedge clk);
    @(negedge clk);
    chk("en.busy_next",  bus.busy, 1'b0);
    chk("en.drop_cycle", cyc, rd + 1);
    repeat (TMO + 20) @(negedge clk);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    repeat (5) @(negedge clk);
    chk("en.fe_cnt",  fe_cnt - fe0, 0);
    chk("en.bv_cnt",  bv_cnt - bv0, 0);
    chk("en.kv_cnt",  kv_cnt - kv0, 0);
    chk("en.busy",    bus.busy, 1'b0);
    @(posedge clk); #1 bus.rx_en = 1'b1;
    run_frame("en.after74", mk_frame(8'h74, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 9'h074, 1'b0, 8'h74);

    // Random frames against a frame-level model.
    m_ext = 1'b0; m_brk = 1'b0; m_code = 9'h074; m_kbrk = 1'b0; m_bdata = 8'h74;
    for (int k = 0; k < 40; k++) begin
      int r, ones, val;
      bit good, e_kv;
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else            b = 8'($urandom);
      f = mk_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      ones = 0; val = 0;
      for (int i = 0; i < 8; i++) begin
        val  += int'(f[1+i]) * (1 << i);
        ones += int'(f[1+i]);
      end
      ones += int'(f[9]);
      good = (f[0] == 1'b0) && (ones % 2 == 1) && (f[10] == 1'b1);
      e_kv = 1'b0;
      if (good) begin
        m_bdata = 8'(val);
        if (val == 'hE0)      m_ext = 1'b1;
        else if (val == 'hF0) m_brk = 1'b1;
        else begin
          e_kv   = 1'b1;
          m_code = {m_ext, 8'(val)};
          m_kbrk = m_brk;
          m_ext  = 1'b0;
          m_brk  = 1'b0;
        end
      end else begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      run_frame($sformatf("rnd%0d", k), f, good, !good, e_kv, m_code, m_kbrk, m_bdata);
    end

    chk("no_back_to_back_pulses", consec, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
PS/2 keyboard receive controller. It sequences the two debounced PS/2 lines, ps2 clock and ps2 data, each taken from its own low-pass filter instance. It frames 11-bit PS/2 packets, checks start, parity and stop bits, and runs a mid-frame timeout. Validated bytes are decoded into make/break key events, handling the E0 (extended) and F0 (break) prefixes, and passed to the keyboard logic above it.

Parameters:
TIMEOUT_CYCLES, 50000, number of clk cycles without a ps2 clock falling edge, while inside a frame, before the frame is aborted.
TIMEOUT_W, 16, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
rx_en  in  1  receive enable; low holds the FSM in IDLE
ps2_clk_filt  in  1  filtered PS/2 clock
ps2_data_filt  in  1  filtered PS/2 data
byte_valid  out  1  one-cycle pulse: a good byte was received
byte_data  out  8  last good byte; holds its value between pulses
frame_err  out  1  one-cycle pulse: frame aborted (start ok, then parity, stop or timeout failure)
key_valid  out  1  one-cycle pulse: key event available
key_code  out  9  {ext, scancode} of the event
key_break  out  1  qualifies key_valid: 1 = release, 0 = press
busy  out  1  high while FSM is not IDLE

Behaviour:
- Reset (resetN=0, asynchronous): FSM=IDLE, all outputs 0, shift register 0, bit counter 0, timeout counter 0, ext/brk flags 0.
- Clock edge register clk_d resets to 0, not 1. The filters power up at 0 and then rise, so no false falling edge may occur after reset.
- fall = clk_d & ~ps2_clk_filt, evaluated every cycle. ps2_data_filt is sampled in the same cycle fall=1.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - on fall with data=0 -> DATA, bit counter=0.
  - on fall with data=1 -> stay IDLE, no error.
  - rx_en=0 -> stay IDLE, ignore edges.
- DATA: on each fall, shift the data bit in LSB-first (new bit enters bit 7, shift right). After the 8th bit -> PARITY.
- PARITY: on fall, store the parity bit -> STOP.
- STOP: on fall -> IDLE.
  - Good if (XOR of 8 data bits ^ parity)==1 (odd parity) and stop bit==1.
  - Good: registered at the next clk edge, so byte_valid=1 for exactly one cycle starting the cycle after the stop-bit fall; byte_data updated at the same edge.
  - Bad: frame_err=1 for one cycle with the same timing; byte_data unchanged; ext/brk cleared.
- Timeout:
  - Counter cleared in IDLE and on every fall; increments in any other state.
  - When it reaches TIMEOUT_CYCLES-1 with no fall: -> IDLE, frame_err one-cycle pulse next cycle, ext/brk cleared.
  - A fall in the same cycle as the limit wins: no timeout.
- rx_en deasserted mid-frame: -> IDLE next cycle, no frame_err, ext/brk cleared, no partial byte output.
- Key decode, on a good byte (same edge that raises byte_valid):
  - 0xE0: ext=1, no key_valid.
  - 0xF0: brk=1, no key_valid.
  - Any other byte: key_valid=1 (same cycle as byte_valid), key_code={ext, byte}, key_break=brk; then ext=0, brk=0.
  - key_code and key_break hold their value until the next event.
- Simultaneous events: reset dominates all; rx_en=0 dominates fall; fall dominates timeout.
- byte_valid, frame_err and key_valid are never high for two consecutive cycles.
- busy = (state != IDLE), registered.

Test Plan:
- Reset release with both filtered lines rising 0->1 some cycles later -> no fall acted on, busy=0, no pulses.
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> byte_valid pulse 1 cycle after the stop fall, byte_data=0x1C, key_valid with key_code=0x01C, key_break=0.
- Frames F0, 1C -> single key_valid, key_code=0x01C, key_break=1; no key_valid on F0.
- Frames E0, F0, 75 -> single key_valid, key_code=0x175, key_break=1; flags 0 afterwards (next 0x1C gives key_code=0x01C, key_break=0).
- Frame 0x1C with parity bit 1 -> frame_err pulse, no byte_valid, byte_data keeps previous value. Frame E0 followed by a bad frame, then 0x74 -> key_code=0x074 (ext cleared).
- Frame stopped after 4 data bits with TIMEOUT_CYCLES=100 -> frame_err exactly 100 cycles after the last fall plus 1; FSM IDLE; next full frame 0x29 received correctly. Repeat with rx_en dropped mid-frame -> no frame_err.
